// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared constants and constant-evaluable helpers for the push-button
// conditioner (debounce_bank / debounce_channel).
//   IDLE_LEVEL  : normalised "not pressed" value held by synchronisers in reset
//   clog2_min1  : $clog2 clamped to at least 1 bit (counter widths)
//   max2        : larger of two integers (hold counter width derivation)
// -----------------------------------------------------------------------------
package debounce_pkg;

    localparam logic IDLE_LEVEL = 1'b0;

    function automatic int clog2_min1(input int x);
        int r;
        r = $clog2(x);
        if (r < 1) begin
            r = 1;
        end else begin
            r = r;
        end
        return r;
    endfunction

    function automatic int max2(input int a, input int b);
        int r;
        if (a > b) begin
            r = a;
        end else begin
            r = b;
        end
        return r;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// Single push-button channel: two-flop synchroniser, polarity normalisation,
// stability filter, debounced level, press/release strobes and optional
// auto-repeat strobe.
// Ports:
//   clk         in  system clock (rising edge)
//   rst_n       in  asynchronous active-low reset
//   btn_raw     in  asynchronous pad input
//   btn_level   out debounced level, 1 = pressed
//   btn_press   out one-cycle strobe on debounced 0->1
//   btn_release out one-cycle strobe on debounced 1->0
//   btn_repeat  out one-cycle auto-repeat strobe while held (0 if disabled)
// -----------------------------------------------------------------------------
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 262144,
    parameter int ACTIVE_LOW    = 1,
    parameter int REPEAT_EN     = 0,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat
);

    localparam int                CNT_W    = clog2_min1(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic              POL      = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic             sync0_r;
    logic             sync1_r;
    logic [CNT_W-1:0] cnt_r;
    logic             level_r;
    logic             press_r;
    logic             release_r;
    logic             flip_s;

    // The debounced state flips on the last cycle of an unbroken disagreement run
    assign flip_s = (sync1_r != level_r) && (cnt_r == CNT_LAST);

    // Two-flop synchroniser on the polarity-normalised pad input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_r <= IDLE_LEVEL;
            sync1_r <= IDLE_LEVEL;
        end else begin
            sync0_r <= btn_raw ^ POL;
            sync1_r <= sync0_r;
        end
    end

    // Stability filter plus registered level and edge strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= '0;
            level_r   <= IDLE_LEVEL;
            press_r   <= 1'b0;
            release_r <= 1'b0;
        end else begin
            // Any cycle of agreement restarts the run; flip also clears it
            if ((sync1_r == level_r) || flip_s) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            if (flip_s) begin
                level_r <= sync1_r;
            end else begin
                level_r <= level_r;
            end
            press_r   <= flip_s & sync1_r;
            release_r <= flip_s & ~sync1_r;
        end
    end

    assign btn_level   = level_r;
    assign btn_press   = press_r;
    assign btn_release = release_r;

    if (REPEAT_EN != 0) begin : g_rep
        localparam int                HOLD_W      = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);
        localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
        localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

        logic [HOLD_W-1:0] hold_r;
        logic              first_r;
        logic              repeat_r;
        logic [HOLD_W-1:0] target_s;

        // First repeat waits the long delay, later ones the short period
        always_comb begin
            target_s = PERIOD_LAST;
            if (first_r) begin
                target_s = DELAY_LAST;
            end else begin
                target_s = PERIOD_LAST;
            end
        end

        // Hold counter: restarts at each repeat so it never wraps; the
        // release cycle (flip while level is 1) never produces a repeat
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hold_r   <= '0;
                first_r  <= 1'b1;
                repeat_r <= 1'b0;
            end else if (flip_s && sync1_r) begin
                hold_r   <= '0;
                first_r  <= 1'b1;
                repeat_r <= 1'b0;
            end else if (level_r && !flip_s) begin
                if (hold_r == target_s) begin
                    hold_r   <= '0;
                    first_r  <= 1'b0;
                    repeat_r <= 1'b1;
                end else begin
                    hold_r   <= hold_r + HOLD_W'(1);
                    first_r  <= first_r;
                    repeat_r <= 1'b0;
                end
            end else begin
                hold_r   <= '0;
                first_r  <= 1'b1;
                repeat_r <= 1'b0;
            end
        end

        assign btn_repeat = repeat_r;
    end else begin : g_norep
        assign btn_repeat = 1'b0;
    end

endmodule

// File: rtl/debounce_bank.sv
// -----------------------------------------------------------------------------
// debounce_bank
// N_CH independent push-button conditioners plus an any-press summary.
// Ports:
//   clk         in  system clock (rising edge)
//   rst_n       in  asynchronous active-low reset
//   btn_raw     in  [N_CH] asynchronous pad inputs
//   btn_level   out [N_CH] debounced levels, 1 = pressed
//   btn_press   out [N_CH] one-cycle press strobes
//   btn_release out [N_CH] one-cycle release strobes
//   btn_repeat  out [N_CH] one-cycle auto-repeat strobes
//   press_any   out OR of btn_press
// -----------------------------------------------------------------------------
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int STABLE_CYCLES = 262144,
    parameter int ACTIVE_LOW    = 1,
    parameter int REPEAT_EN     = 0,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_raw,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic [N_CH-1:0] btn_repeat,
    output logic            press_any
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .ACTIVE_LOW    (ACTIVE_LOW),
            .REPEAT_EN     (REPEAT_EN),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .btn_raw     (btn_raw[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .btn_repeat  (btn_repeat[i])
        );
    end

    // Summary strobe is built directly from the registered per-channel strobes
    assign press_any = |btn_press;

endmodule
